keypad_calc_sequencer: RTL
==========================

Name: keypad_calc_sequencer

Overview:
- Sequences keypad entry of two decimal operands, drives a digit-serial BCD adder and selects the value shown on the 3-digit display.
- Sits between the debounced keypad scanner (key code plus valid strobe) and the display path (12-bit BCD `cdu` into the digit mux/decoder).
- Replaces free-running summation with an explicit enter-A / enter-B / add / show flow.

Parameters:
- DIGITS, 3: number of BCD digits per operand and result; `cdu` width = 4*DIGITS.
- KEY_ADD, 4'hA: key code that ends operand A entry.
- KEY_CLR, 4'hE: key code that clears everything (keypad `*`).
- KEY_EQ, 4'hF: key code that starts the addition (keypad `#`).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe from the scanner: a new debounced key press.
- key_code  in  4  key code, valid while key_valid=1; 0-9 are digits.
- cdu  out  4*DIGITS  BCD value to display; digit 0 (units) is in bits [3:0].
- busy  out  1  high while an addition is in progress; keys are ignored.
- ovf  out  1  result exceeded 10^DIGITS-1.
- state_o  out  2  current state, for debug LEDs: 0=ENT_A, 1=ENT_B, 2=ADD, 3=SHOW.

Behaviour:
- Reset (synchronous, active-high):
  - state=ENT_A; A, B, R, digit counts cleared.
  - cdu=0, busy=0, ovf=0.
  - Reset wins over any simultaneous key_valid. Reset during ADD aborts the add with no partial result kept.
- Key sampling: key_valid and key_code are sampled on the clk edge. Every effect is visible on the outputs 1 cycle later (registered outputs). Each key_valid=1 cycle counts as one key press.
- Digit entry, in ENT_A and ENT_B:
  - Operand shifts left one BCD digit; new digit loads the units position; digit count increments.
  - If the count already equals DIGITS, the digit is ignored (no shift, no wrap).
  - Leading zeros count as digits.
- KEY_CLR: in every state except ADD, clears A, B, R and ovf and goes to ENT_A.
- ENT_A:
  - KEY_ADD → ENT_B with B=0, B count=0.
  - KEY_EQ → ignored.
  - codes B/C/D → ignored.
- ENT_B:
  - KEY_EQ → ADD with digit index=0, carry=0, R=0.
  - KEY_ADD and codes B/C/D → ignored.
- ADD (busy=1):
  - One BCD digit per cycle, units first.
  - s = A[i] + B[i] + carry. If s > 9: R[i] = s+6 (low 4 bits), carry=1. Otherwise R[i] = s, carry=0.
  - After DIGITS cycles → SHOW; ovf = final carry.
  - Total latency from the KEY_EQ sample to SHOW with valid cdu: DIGITS+1 cycles.
  - All keys ignored, including KEY_CLR.
- SHOW:
  - Digit key: A = that digit, A count=1, ovf cleared, → ENT_A (starts a new calculation).
  - KEY_ADD: A=R (count=DIGITS), B=0, ovf cleared, → ENT_B (chained addition).
  - KEY_EQ: ignored.
  - On overflow the result is shown modulo 10^DIGITS and ovf stays high until SHOW is left.
- cdu source:
  - ENT_A → A.
  - ENT_B → B.
  - ADD → B (held; no partial results shown).
  - SHOW → R.
- busy=1 only in ADD. state_o follows the state register.

Optional Feature:
- Macro: CALC_SUB_EN.
- Defined:
  - Key code 4'hB in ENT_A acts like KEY_ADD but selects subtraction.
  - ADD does BCD subtract digit by digit: d = A[i] - B[i] - borrow. If d < 0: add 10 and set borrow=1.
  - If the final borrow=1, R = 10's complement of the raw result (the magnitude) and ovf=1, meaning a negative result.
  - Same latency as addition.
- Not defined: 4'hB is ignored everywhere; only addition exists.

Test Plan:
- Reset, then keys 1,2,3 → cdu=12'h123 one cycle after each strobe, in the sequence 001, 012, 123. A 4th key 4 → cdu stays 12'h123.
- Keys 4,5,A,5,5,F → busy=1 for exactly 3 cycles starting 1 cycle after F; then state_o=3, cdu=12'h100, ovf=0.
- Keys 9,9,9,A,1,F → cdu=12'h000, ovf=1. Next key 7 → state_o=0, cdu=12'h007, ovf=0.
- Chaining: 2,0,0,A,3,0,0,F then A,1,F → first result 12'h500, final result 12'h501.
- KEY_CLR (E) pressed during ADD → ignored, result is still correct. KEY_CLR in ENT_B → cdu=0, state_o=0.
- Reset asserted in the 2nd ADD cycle together with key_valid=1 → next cycle state_o=0, cdu=0, busy=0, ovf=0.
- With CALC_SUB_EN: keys 1,0,B,2,5,F → cdu=12'h015, ovf=1 (negative).

Source files
------------

// File: rtl/keypad_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : keypad_calc_sequencer
// Purpose  : Keypad entry of two BCD operands, digit-serial BCD add, display
//            select. Optional subtraction via macro CALC_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_calc_sequencer #(
  parameter int         DIGITS  = 3,
  parameter logic [3:0] KEY_ADD = 4'hA,
  parameter logic [3:0] KEY_CLR = 4'hE,
  parameter logic [3:0] KEY_EQ  = 4'hF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   cdu,
  output logic                  busy,
  output logic                  ovf,
  output logic [1:0]            state_o
);

  localparam int c_OP_W  = 4*DIGITS;
  localparam int c_CNT_W = $clog2(DIGITS+1);
  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_ENT_A = 2'd0,
    ST_ENT_B = 2'd1,
    ST_ADD   = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_OP_W-1:0]   r_a, r_b, r_r, r_cdu;
  logic [c_OP_W-1:0]   w_a_nxt, w_b_nxt, w_r_nxt, w_cdu_nxt, w_r_upd;
  logic [c_CNT_W-1:0]  r_cnt_a, r_cnt_b, w_cnt_a_nxt, w_cnt_b_nxt;
  logic [c_IDX_W-1:0]  r_idx, w_idx_nxt;
  logic                r_carry, w_carry_nxt, r_ovf, w_ovf_nxt;
  logic [3:0]          w_dig_a, w_dig_b, w_dig_r;
  logic [4:0]          w_sum;
  logic                w_cy;
  logic                w_is_digit;

`ifdef CALC_SUB_EN
  localparam logic [3:0] c_KEY_SUB = 4'hB;
  logic                r_sub, w_sub_nxt;
  logic [4:0]          w_dif;

  // Magnitude of a negative result: 10^DIGITS - v, digit by digit.
  function automatic logic [c_OP_W-1:0] tens_comp(input logic [c_OP_W-1:0] v);
    logic [c_OP_W-1:0] res;
    logic [4:0]        t;
    logic              c;
    res = '0;
    c   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      t = 5'd9 - {1'b0, v[4*k +: 4]} + {4'd0, c};
      if (t > 5'd9) begin
        res[4*k +: 4] = t[3:0] - 4'd10;
        c = 1'b1;
      end else begin
        res[4*k +: 4] = t[3:0];
        c = 1'b0;
      end
    end
    return res;
  endfunction
`endif

  // Digit slice selected by the add index, and the updated result word.
  always_comb begin
    w_dig_a = '0;
    w_dig_b = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == c_IDX_W'(k)) begin
        w_dig_a = r_a[4*k +: 4];
        w_dig_b = r_b[4*k +: 4];
      end
    end
  end

  always_comb begin
    w_sum   = {1'b0, w_dig_a} + {1'b0, w_dig_b} + {4'd0, r_carry};
    w_dig_r = w_sum[3:0];
    w_cy    = 1'b0;
    if (w_sum > 5'd9) begin
      w_dig_r = w_sum[3:0] + 4'd6;
      w_cy    = 1'b1;
    end
`ifdef CALC_SUB_EN
    w_dif = {1'b0, w_dig_a} - {1'b0, w_dig_b} - {4'd0, r_carry};
    if (r_sub) begin
      w_dig_r = w_dif[3:0];
      w_cy    = w_dif[4];
      if (w_dif[4]) w_dig_r = w_dif[3:0] + 4'd10;
    end
`endif
    w_r_upd = r_r;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == c_IDX_W'(k)) w_r_upd[4*k +: 4] = w_dig_r;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_r_nxt     = r_r;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    w_idx_nxt   = r_idx;
    w_carry_nxt = r_carry;
    w_ovf_nxt   = r_ovf;
`ifdef CALC_SUB_EN
    w_sub_nxt   = r_sub;
`endif
    w_is_digit  = (key_code <= 4'd9);

    if (r_state == ST_ADD) begin
      w_r_nxt     = w_r_upd;
      w_carry_nxt = w_cy;
      w_idx_nxt   = r_idx + c_IDX_W'(1);
      if (r_idx == c_IDX_W'(DIGITS-1)) begin
        w_state_nxt = ST_SHOW;
        w_idx_nxt   = '0;
        w_ovf_nxt   = w_cy;
`ifdef CALC_SUB_EN
        if (r_sub && w_cy) w_r_nxt = tens_comp(w_r_upd);
`endif
      end
    end else if (key_valid) begin
      if (key_code == KEY_CLR) begin
        w_state_nxt = ST_ENT_A;
        w_a_nxt     = '0;
        w_b_nxt     = '0;
        w_r_nxt     = '0;
        w_cnt_a_nxt = '0;
        w_cnt_b_nxt = '0;
        w_ovf_nxt   = 1'b0;
      end else if (key_code == KEY_ADD) begin
        if (r_state == ST_ENT_A || r_state == ST_SHOW) begin
          w_state_nxt = ST_ENT_B;
          w_b_nxt     = '0;
          w_cnt_b_nxt = '0;
          w_ovf_nxt   = 1'b0;
`ifdef CALC_SUB_EN
          w_sub_nxt   = 1'b0;
`endif
          // Chained addition: the shown result becomes the new A.
          if (r_state == ST_SHOW) begin
            w_a_nxt     = r_r;
            w_cnt_a_nxt = c_CNT_W'(DIGITS);
          end
        end
`ifdef CALC_SUB_EN
      end else if (key_code == c_KEY_SUB) begin
        if (r_state == ST_ENT_A) begin
          w_state_nxt = ST_ENT_B;
          w_b_nxt     = '0;
          w_cnt_b_nxt = '0;
          w_sub_nxt   = 1'b1;
        end
`endif
      end else if (key_code == KEY_EQ) begin
        if (r_state == ST_ENT_B) begin
          w_state_nxt = ST_ADD;
          w_idx_nxt   = '0;
          w_carry_nxt = 1'b0;
          w_r_nxt     = '0;
        end
      end else if (w_is_digit) begin
        case (r_state)
          ST_ENT_A: if (r_cnt_a != c_CNT_W'(DIGITS)) begin
            w_a_nxt      = r_a << 4;
            w_a_nxt[3:0] = key_code;
            w_cnt_a_nxt  = r_cnt_a + c_CNT_W'(1);
          end
          ST_ENT_B: if (r_cnt_b != c_CNT_W'(DIGITS)) begin
            w_b_nxt      = r_b << 4;
            w_b_nxt[3:0] = key_code;
            w_cnt_b_nxt  = r_cnt_b + c_CNT_W'(1);
          end
          ST_SHOW: begin
            w_state_nxt  = ST_ENT_A;
            w_a_nxt      = '0;
            w_a_nxt[3:0] = key_code;
            w_cnt_a_nxt  = c_CNT_W'(1);
            w_ovf_nxt    = 1'b0;
          end
          default: ;
        endcase
      end
    end

    case (w_state_nxt)
      ST_ENT_A: w_cdu_nxt = w_a_nxt;
      ST_SHOW:  w_cdu_nxt = w_r_nxt;
      default:  w_cdu_nxt = w_b_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ENT_A;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_cdu   <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef CALC_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_r     <= w_r_nxt;
      r_cdu   <= w_cdu_nxt;
      r_cnt_a <= w_cnt_a_nxt;
      r_cnt_b <= w_cnt_b_nxt;
      r_idx   <= w_idx_nxt;
      r_carry <= w_carry_nxt;
      r_ovf   <= w_ovf_nxt;
`ifdef CALC_SUB_EN
      r_sub   <= w_sub_nxt;
`endif
    end
  end

  assign cdu     = r_cdu;
  assign ovf     = r_ovf;
  assign busy    = (r_state == ST_ADD);
  assign state_o = r_state;

endmodule
`default_nettype wire
